// File: rtl/serial_adder.sv
// ----------------------------------------------------------------------------
// serial_adder
//   Bit-serial unsigned adder. Captures a and b on an accepted start and adds
//   them LSB-first, one bit per clock. The datapath is a single full-adder
//   cell built from two half adders and an OR, plus a carry flop. Presents a
//   registered sum/cout and a one-cycle done pulse once all WIDTH bits are in.
//
// Ports
//   clk    in   1      clock, rising edge
//   rst    in   1      asynchronous active-high reset
//   start  in   1      add request, sampled only while idle
//   a      in   WIDTH  operand A, captured on accepted start
//   b      in   WIDTH  operand B, captured on accepted start
//   busy   out  1      high while an operation is running or completing
//   done   out  1      one-cycle pulse, sum/cout valid
//   sum    out  WIDTH  a + b mod 2^WIDTH, held until the next completion
//   cout   out  1      carry out of bit WIDTH-1, held with sum
// ----------------------------------------------------------------------------
module serial_adder #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic [WIDTH-1:0] ps;
    logic [WIDTH-1:0] ps_nxt;
    logic             c;
    logic [CW-1:0]    cnt;

    logic load_c;
    logic step_c;
    logic last_c;

    logic ha0_s;
    logic ha0_c;
    logic ha1_c;
    logic fa_s;
    logic fa_c;

    // Full-adder cell: two half adders, carries merged by an OR.
    always_comb begin
        ha0_s  = sa[0] ^ sb[0];
        ha0_c  = sa[0] & sb[0];
        fa_s   = ha0_s ^ c;
        ha1_c  = ha0_s & c;
        fa_c   = ha0_c | ha1_c;
        // New sum bit enters at the MSB so the LSB lands in bit 0 after WIDTH steps.
        ps_nxt = {fa_s, ps[WIDTH-1:1]};
    end

    // Next-state and datapath control.
    always_comb begin
        state_nxt = state;
        load_c    = 1'b0;
        step_c    = 1'b0;
        last_c    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    load_c    = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                step_c = 1'b1;
                if (cnt == LAST_BIT) begin
                    last_c    = 1'b1;
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State register; busy/done registered from the next state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_nxt;
            busy  <= (state_nxt != IDLE);
            done  <= (state_nxt == DONE);
        end
    end

    // Operand shifters, carry, bit counter and result registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sa   <= '0;
            sb   <= '0;
            ps   <= '0;
            c    <= 1'b0;
            cnt  <= '0;
            sum  <= '0;
            cout <= 1'b0;
        end else if (load_c) begin
            sa  <= a;
            sb  <= b;
            ps  <= '0;
            c   <= 1'b0;
            cnt <= '0;
        end else if (step_c) begin
            sa  <= sa >> 1;
            sb  <= sb >> 1;
            ps  <= ps_nxt;
            c   <= fa_c;
            cnt <= cnt + CW'(1);
            // Results only update on the final bit, never showing partials.
            if (last_c) begin
                sum  <= ps_nxt;
                cout <= fa_c;
            end
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// ----------------------------------------------------------------------------
// tb_serial_adder
//   Scoreboard bench for serial_adder (WIDTH=8). The driver pushes the
//   expected {cout,sum} and acceptance cycle for each accepted add; a monitor
//   on the falling edge pops and compares on every done pulse.
// ----------------------------------------------------------------------------
module tb_serial_adder;

    localparam int unsigned WIDTH = 8;

    logic             clk;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;

    typedef struct {
        logic [WIDTH-1:0] sum;
        logic             cout;
        int               acc;
    } exp_t;

    exp_t q[$];

    int n_vec      = 0;
    int n_err      = 0;
    int cyc        = 0;
    int done_count = 0;
    logic prev_done = 1'b0;

    serial_adder #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Monitor: every done pulse must be single-cycle and match the scoreboard head.
    always @(negedge clk) begin
        if (done) begin
            exp_t e;
            chk("done_width", 32'(prev_done), 32'd0);
            chk("sb_nonempty", 32'(q.size() != 0), 32'd1);
            if (q.size() != 0) begin
                e = q.pop_front();
                chk("sum", 32'(sum), 32'(e.sum));
                chk("cout", 32'(cout), 32'(e.cout));
                chk("latency", 32'(cyc - e.acc), 32'(WIDTH));
            end
            done_count++;
        end
        prev_done = done;
    end

    // Wait (bounded) until the DUT is idle; caller sits #1 after a rising edge.
    task automatic wait_idle();
        int n;
        n = 0;
        while (busy === 1'b1 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (busy !== 1'b0) chk("idle_timeout", 32'(busy), 32'd0);
    endtask

    // Issue one add after gap idle cycles and push its expected result.
    task automatic do_add(input logic [WIDTH-1:0] xa, input logic [WIDTH-1:0] xb, input int gap);
        logic [WIDTH:0] r;
        exp_t e;
        wait_idle();
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
        start = 1'b1;
        a     = xa;
        b     = xb;
        @(posedge clk);
        #1;
        r      = {1'b0, xa} + {1'b0, xb};
        e.sum  = r[WIDTH-1:0];
        e.cout = r[WIDTH];
        e.acc  = cyc;
        q.push_back(e);
        start = 1'b0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_sum"},  32'(sum),  32'd0);
        chk({tag, "_cout"}, 32'(cout), 32'd0);
    endtask

    initial begin
        int   nb;
        int   dc0;
        exp_t e;

        rst   = 1'b0;
        start = 1'b0;
        a     = '0;
        b     = '0;

        // Power-on reset, checked before any clock edge.
        #1 rst = 1'b1;
        #1 chk_reset_outputs("por");
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;

        // Basic add and carry-chain corners.
        do_add(8'h35, 8'h4A, 0);
        wait_idle();
        chk("basic_sum_held", 32'(sum), 32'h7F);

        // Asynchronous reset mid-cycle clears results at once.
        @(posedge clk);
        #3 rst = 1'b1;
        #1 chk_reset_outputs("async_rst");
        @(posedge clk);
        #1 rst = 1'b0;

        do_add(8'hFF, 8'h01, 1);
        do_add(8'hFF, 8'hFF, 0);
        do_add(8'h00, 8'h00, 2);
        wait_idle();

        // Start held through the whole operation with operands changed after acceptance.
        dc0   = done_count;
        start = 1'b1;
        a     = 8'h12;
        b     = 8'h34;
        @(posedge clk);
        #1;
        e.sum = 8'h46; e.cout = 1'b0; e.acc = cyc;
        q.push_back(e);
        a  = 8'hFF;
        b  = 8'hFF;
        nb = 0;
        while (busy === 1'b1 && nb < 100) begin
            @(posedge clk);
            #1;
            nb++;
        end
        chk("busy_cycles", 32'(nb), 32'(WIDTH + 1));
        chk("one_done_while_held", 32'(done_count - dc0), 32'd1);
        // Still held once idle: the next edge accepts the new operands.
        @(posedge clk);
        #1;
        e.sum = 8'hFE; e.cout = 1'b1; e.acc = cyc;
        q.push_back(e);
        start = 1'b0;
        chk("reaccept_busy", 32'(busy), 32'd1);
        wait_idle();
        chk("two_dones_total", 32'(done_count - dc0), 32'd2);

        // Reset mid-operation: aborted add produces no done and zero results.
        dc0   = done_count;
        start = 1'b1;
        a     = 8'h80;
        b     = 8'h80;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        #1 chk_reset_outputs("midop_rst");
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (12) @(posedge clk);
        #1 chk("no_done_after_abort", 32'(done_count - dc0), 32'd0);
        do_add(8'h10, 8'h20, 0);
        wait_idle();
        chk("post_abort_sum", 32'(sum), 32'h30);

        // Random operands with random start gaps.
        for (int i = 0; i < 1000; i++) begin
            do_add(WIDTH'($urandom), WIDTH'($urandom), int'($urandom_range(0, 3)));
        end
        wait_idle();
        @(posedge clk);
        #1 chk("sb_drained", 32'(q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
